eth_udp_sched: RTL and testbench
================================

// Module: eth_udp_sched
// PURPOSE
//  Round-robin scheduler sharing one eth_phydirect UDP transmit path between NREQ requesters.
//  Grants one requester, pulses the PHY start, and muxes that requester's length, port and data.
//  Counts PHY data reads to detect end of packet, then enforces an inter-packet gap.
//  Runs in the PHY user clock domain (usr_clk_o of eth_phydirect).
// PARAMETERS
//  NREQ        2      number of requesters (2..8)
//  MAX_LEN     16'd1472  max UDP payload bytes; larger requests are clamped to this value
//  IFG_CYC     32     idle cycles after each packet before the next grant (>=1)
//  TIMEOUT_CYC 4096   max cycles without phy_datard_i in WAIT/STREAM before abort
// PORTS
//  clk_i          in   1        PHY user clock
//  reset_n_i      in   1        async reset, active low
//  req_i          in   NREQ     level request, one bit per requester
//  len_i          in   NREQ*16  payload length per requester; sampled at grant
//  udpport_i      in   NREQ*16  UDP port per requester; sampled at grant
//  data_i         in   NREQ*8   payload byte per requester
//  grant_o        out  NREQ     one-hot; high from grant until done/err
//  datard_o       out  NREQ     byte-consumed strobe, routed to granted requester only
//  done_o         out  NREQ     1-cycle pulse: packet complete
//  err_o          out  NREQ     1-cycle pulse: packet aborted on timeout
//  busy_o         out  1        state != IDLE
//  phy_start_o    out  1        1-cycle start pulse to PHY (usr_start_i)
//  phy_len_o      out  16       latched length (usr_data_len_i)
//  phy_udpport_o  out  16       latched port (usr_udpport_i)
//  phy_data_o     out  8        data_i of granted requester (usr_data_i)
//  phy_datard_i   in   1        PHY byte-read strobe (usr_datard_o)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, counters 0. Takes effect immediately, even mid-packet.
//  IDLE: if any req_i, pick first set bit at/after rr pointer.
//   Next cycle: grant_o set; len and port latched; rr pointer = winner+1 mod NREQ.
//   len==0: done_o pulse with the grant, no phy_start_o, go to GAP. Otherwise phy_start_o pulses and go to WAIT.
//  WAIT: first phy_datard_i -> STREAM; that strobe counts as byte 1.
//  STREAM: each phy_datard_i increments a 16-bit byte counter.
//   Counter reaching len -> next cycle done_o pulse, grant_o cleared -> GAP.
//  Timeout: watchdog counter reset by each phy_datard_i; TIMEOUT_CYC elapses in WAIT/STREAM ->
//   err_o pulse, grant_o cleared -> GAP.
//  GAP: count IFG_CYC cycles -> IDLE. phy_datard_i ignored in IDLE/GAP; datard_o stays 0.
//  datard_o and phy_data_o are combinational muxes on the latched grant; zero latency to the PHY.
//  req_i dropping mid-packet is ignored; the packet completes. A requester re-requesting after done waits one full rr turn.
//  Clamp: len_i > MAX_LEN -> phy_len_o = MAX_LEN; byte count compares against the clamped value.
// CONFIGURATION
//  ETH_SCHED_STATS_EN defined: adds outputs pkt_cnt_o (NREQ*16) and err_cnt_o (NREQ*16).
//   These are wrapping per-requester counters of done/err pulses, reset to 0.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package eth_sched_pkg: state encoding (IDLE, WAIT, STREAM, GAP), byte-count width 16, counter widths.
//  Sub-module eth_rr_arbiter: combinational NREQ round-robin pick (req, ptr -> one-hot grant, valid).
// TESTING
//  1. Reset low mid-STREAM -> all outputs 0 same cycle; after release, IDLE; new req gets granted normally.
//  2. req_i=2'b01, len=4 -> phy_start_o 1 cycle; 4 datard_o[0] strobes; done_o[0] 1 cycle after the 4th strobe;
//     no grant for 32 cycles.
//  3. req_i=2'b11 held -> grants alternate 0,1,0,1; each packet of len 8 consumes data_i of its own requester.
//  4. len_i=0 on req 1 -> done_o[1] pulse, phy_start_o never asserts, GAP entered.
//  5. len_i=16'd2000 -> phy_len_o=1472; done_o after exactly 1472 strobes.
//  6. No phy_datard_i for 4096 cycles after start -> err_o pulse, grant dropped, next request serviced.
//     With ETH_SCHED_STATS_EN, err_cnt_o increments by 1.

Source files
------------

// File: rtl/eth_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_sched_pkg
// Description : Shared types and constants for the eth_udp_sched UDP transmit
//               scheduler: FSM state encoding, field widths, index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_sched_pkg;

    localparam int LEN_W  = 16;   // byte count / length / port width
    localparam int STAT_W = 16;   // statistics counter width
    localparam int IDX_W  = 3;    // requester index width (up to 8 requesters)

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // Index of the set bit in a one-hot vector (0 when no bit is set).
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [7:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_udp_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_udp_sched_if
// Description : Requester/PHY signal bundle of the UDP transmit scheduler.
//               slave = scheduler side, master = requesters + PHY side.
//               ETH_SCHED_STATS_EN adds the per-requester statistics buses.
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_udp_sched_if #(
    parameter int NREQ = 2
);
    import eth_sched_pkg::*;

    logic [NREQ-1:0]       req_i;
    logic [NREQ*LEN_W-1:0] len_i;
    logic [NREQ*LEN_W-1:0] udpport_i;
    logic [NREQ*8-1:0]     data_i;
    logic [NREQ-1:0]       grant_o;
    logic [NREQ-1:0]       datard_o;
    logic [NREQ-1:0]       done_o;
    logic [NREQ-1:0]       err_o;
    logic                  busy_o;
    logic                  phy_start_o;
    logic [LEN_W-1:0]      phy_len_o;
    logic [LEN_W-1:0]      phy_udpport_o;
    logic [7:0]            phy_data_o;
    logic                  phy_datard_i;
`ifdef ETH_SCHED_STATS_EN
    logic [NREQ*STAT_W-1:0] pkt_cnt_o;
    logic [NREQ*STAT_W-1:0] err_cnt_o;
`endif

    modport slave (
        input  req_i, len_i, udpport_i, data_i, phy_datard_i,
`ifdef ETH_SCHED_STATS_EN
        output pkt_cnt_o, err_cnt_o,
`endif
        output grant_o, datard_o, done_o, err_o, busy_o,
        output phy_start_o, phy_len_o, phy_udpport_o, phy_data_o
    );

    modport master (
        output req_i, len_i, udpport_i, data_i, phy_datard_i,
`ifdef ETH_SCHED_STATS_EN
        input  pkt_cnt_o, err_cnt_o,
`endif
        input  grant_o, datard_o, done_o, err_o, busy_o,
        input  phy_start_o, phy_len_o, phy_udpport_o, phy_data_o
    );

endinterface
`default_nettype wire

// File: rtl/eth_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_rr_arbiter
// Description : Combinational round-robin pick: first set request at or after
//               ptr (wrapping), returned one-hot, plus a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rr_arbiter
    import eth_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic             valid
);

    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] rot_oh;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot    = NREQ'({req, req} >> ptr);
        rot_oh = rot & (~rot + NREQ'(1));
        grant  = NREQ'(({rot_oh, rot_oh} << ptr) >> NREQ);
        valid  = |req;
    end

endmodule
`default_nettype wire

// File: rtl/eth_udp_sched.sv
`default_nettype none
// ============================================================================
// Module      : eth_udp_sched
// Description : Round-robin scheduler sharing one UDP transmit path between
//               NREQ requesters: grant, PHY start pulse, length/port/data mux,
//               end-of-packet byte count, read watchdog and inter-packet gap.
//               Optional macro ETH_SCHED_STATS_EN adds per-requester
//               done/err counters (pkt_cnt_o, err_cnt_o).
// Revision    : 1.0 - initial release
// ============================================================================
module eth_udp_sched
    import eth_sched_pkg::*;
#(
    parameter int               NREQ        = 2,
    parameter logic [LEN_W-1:0] MAX_LEN     = 16'd1472,
    parameter int               IFG_CYC     = 32,
    parameter int               TIMEOUT_CYC = 4096
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    eth_udp_sched_if.slave bus
);

    localparam int               WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int               GAP_W    = $clog2(IFG_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYC - 1);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NREQ - 1);

    state_t             state, state_nx;
    logic [NREQ-1:0]    grant, done, err, arb_grant, datard;
    logic               arb_valid, phy_start, busy;
    logic [LEN_W-1:0]   phy_len, phy_port, sel_len, sel_port, clamp_len;
    logic [LEN_W-1:0]   byte_cnt, cnt_inc;
    logic [IDX_W-1:0]   rr_ptr, win_idx;
    logic [WD_W-1:0]    wdog;
    logic [GAP_W-1:0]   gap_cnt;
    logic [7:0]         data_mux;
    logic               in_xfer, last_byte, timeout, gap_end, take;

    eth_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_i),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Winner's length (clamped) and port, plus its index for the rr pointer.
    always_comb begin
        sel_len  = '0;
        sel_port = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_len  = bus.len_i[i*LEN_W +: LEN_W];
                sel_port = bus.udpport_i[i*LEN_W +: LEN_W];
            end
        end
        clamp_len = (sel_len > MAX_LEN) ? MAX_LEN : sel_len;
        win_idx   = onehot_idx(8'(arb_grant));
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= ST_IDLE;
        else            state <= state_nx;
    end

    // Next-state logic and the end-of-packet / timeout / gap decisions.
    always_comb begin
        in_xfer   = (state == ST_WAIT) || (state == ST_STREAM);
        cnt_inc   = byte_cnt + LEN_W'(1);
        last_byte = in_xfer && bus.phy_datard_i && (cnt_inc == phy_len);
        timeout   = in_xfer && !bus.phy_datard_i && (wdog == WD_LAST);
        gap_end   = (state == ST_GAP) && (gap_cnt == GAP_LAST);
        take      = (state == ST_IDLE) && arb_valid;
        state_nx  = state;
        case (state)
            ST_IDLE:   if (take) state_nx = (clamp_len == '0) ? ST_GAP : ST_WAIT;
            ST_WAIT:   if (last_byte || timeout) state_nx = ST_GAP;
                       else if (bus.phy_datard_i) state_nx = ST_STREAM;
            ST_STREAM: if (last_byte || timeout) state_nx = ST_GAP;
            ST_GAP:    if (gap_end) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Combinational outputs: busy flag and zero-latency strobe/data routing.
    always_comb begin
        busy     = (state != ST_IDLE);
        datard   = (in_xfer && bus.phy_datard_i) ? grant : '0;
        data_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) data_mux = bus.data_i[i*8 +: 8];
        end
    end

    // Grant, latched packet parameters, pulses and counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grant     <= '0;
            done      <= '0;
            err       <= '0;
            phy_start <= 1'b0;
            phy_len   <= '0;
            phy_port  <= '0;
            rr_ptr    <= '0;
            byte_cnt  <= '0;
            wdog      <= '0;
            gap_cnt   <= '0;
        end else begin
            done      <= '0;
            err       <= '0;
            phy_start <= 1'b0;
            if (take) begin
                grant    <= arb_grant;
                phy_len  <= clamp_len;
                phy_port <= sel_port;
                rr_ptr   <= (win_idx == PTR_LAST) ? '0 : win_idx + IDX_W'(1);
                byte_cnt <= '0;
                wdog     <= '0;
                // Zero-length packets complete with the grant, PHY untouched.
                if (clamp_len == '0) done <= arb_grant;
                else                 phy_start <= 1'b1;
            end
            if (in_xfer) begin
                if (bus.phy_datard_i) begin
                    byte_cnt <= cnt_inc;
                    wdog     <= '0;
                end else begin
                    wdog <= wdog + WD_W'(1);
                end
                if (last_byte) begin
                    done  <= grant;
                    grant <= '0;
                end
                if (timeout) begin
                    err   <= grant;
                    grant <= '0;
                end
            end
            if (state == ST_GAP) begin
                grant   <= '0;
                gap_cnt <= gap_end ? '0 : gap_cnt + GAP_W'(1);
            end
        end
    end

    assign bus.grant_o       = grant;
    assign bus.done_o        = done;
    assign bus.err_o         = err;
    assign bus.busy_o        = busy;
    assign bus.phy_start_o   = phy_start;
    assign bus.phy_len_o     = phy_len;
    assign bus.phy_udpport_o = phy_port;
    assign bus.phy_data_o    = data_mux;
    assign bus.datard_o      = datard;

`ifdef ETH_SCHED_STATS_EN
    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_stats
            logic [STAT_W-1:0] pkt_q, err_q;
            // Wrapping per-requester completion and abort counters.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    pkt_q <= '0;
                    err_q <= '0;
                end else begin
                    if (done[g]) pkt_q <= pkt_q + STAT_W'(1);
                    if (err[g])  err_q <= err_q + STAT_W'(1);
                end
            end
            assign bus.pkt_cnt_o[g*STAT_W +: STAT_W] = pkt_q;
            assign bus.err_cnt_o[g*STAT_W +: STAT_W] = err_q;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_udp_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_udp_sched
// Description : Self-checking bench for eth_udp_sched: table of packet
//               transactions plus a reset-during-stream sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_udp_sched;

    localparam int NREQ   = 2;
    localparam int IFG    = 32;
    localparam int TMO    = 4096;
    localparam int M_NORM = 0;
    localparam int M_ZERO = 1;
    localparam int M_TMO  = 2;
    localparam int NVEC   = 10;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] len0;
        logic [15:0] len1;
        int          gidx;
        logic [15:0] exp_len;
        logic        exp_start;
        int          mode;
        bit          drop;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_pkt [NREQ];
    int   exp_err [NREQ];
    vec_t vecs [NVEC];
    vec_t post;

    eth_udp_sched_if #(.NREQ(NREQ)) bus ();

    eth_udp_sched #(
        .NREQ        (NREQ),
        .MAX_LEN     (16'd1472),
        .IFG_CYC     (IFG),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dval(input int r, input int b);
        return 8'(b) ^ ((r == 0) ? 8'h5A : 8'hA5);
    endfunction

    // One full transaction: arbitration, stream or timeout, then the gap.
    task automatic run_vec(input vec_t v, input string tag);
        int         waitc;
        bit         ok;
        logic [1:0] eg;
        eg = 2'b01 << v.gidx;
        bus.req_i        = v.req;
        bus.len_i        = {v.len1, v.len0};
        bus.udpport_i    = {16'hC001, 16'hC000};
        bus.data_i       = {dval(1, 0), dval(0, 0)};
        bus.phy_datard_i = 1'b0;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (bus.grant_o == '0 && waitc < 100);
        chk({tag, "/latency"},   32'(waitc), 32'd1);
        chk({tag, "/grant"},     32'(bus.grant_o), 32'(eg));
        chk({tag, "/phy_start"}, 32'(bus.phy_start_o), 32'(v.exp_start));
        chk({tag, "/phy_len"},   32'(bus.phy_len_o), 32'(v.exp_len));
        chk({tag, "/port"},      32'(bus.phy_udpport_o), 32'(16'hC000 | 16'(v.gidx)));
        chk({tag, "/busy"},      32'(bus.busy_o), 32'd1);
        if (v.drop) bus.req_i = '0;
        if (v.mode == M_ZERO) begin
            chk({tag, "/done_zero"}, 32'(bus.done_o), 32'(eg));
            exp_pkt[v.gidx]++;
        end else if (v.mode == M_TMO) begin
            waitc = 0;
            do begin
                @(negedge clk);
                waitc++;
            end while (bus.err_o == '0 && waitc < TMO + 100);
            chk({tag, "/tmo_cycles"}, 32'(waitc), 32'(TMO));
            chk({tag, "/err"},        32'(bus.err_o), 32'(eg));
            chk({tag, "/grant_drop"}, 32'(bus.grant_o), 32'd0);
            exp_err[v.gidx]++;
        end else begin
            chk({tag, "/done_early"}, 32'(bus.done_o), 32'd0);
            @(negedge clk);
            chk({tag, "/start_pulse"}, 32'(bus.phy_start_o), 32'd0);
            ok = 1'b1;
            for (int b = 0; b < int'(v.exp_len); b++) begin
                bus.data_i       = {dval(1, b), dval(0, b)};
                bus.phy_datard_i = 1'b1;
                #1;
                if (bus.datard_o !== eg || bus.phy_data_o !== dval(v.gidx, b) ||
                    bus.done_o !== 2'b00 || bus.grant_o !== eg) ok = 1'b0;
                @(negedge clk);
            end
            bus.phy_datard_i = 1'b0;
            chk({tag, "/stream"},   32'(ok), 32'd1);
            chk({tag, "/done"},     32'(bus.done_o), 32'(eg));
            chk({tag, "/grant_off"}, 32'(bus.grant_o), 32'd0);
            chk({tag, "/no_err"},   32'(bus.err_o), 32'd0);
            exp_pkt[v.gidx]++;
        end
        // Gap: strobes held high must be ignored, nothing granted.
        bus.phy_datard_i = 1'b1;
        ok = 1'b1;
        for (int k = 1; k < IFG; k++) begin
            @(negedge clk);
            #1;
            if (bus.grant_o !== 2'b00 || bus.busy_o !== 1'b1 || bus.datard_o !== 2'b00 ||
                bus.done_o !== 2'b00 || bus.err_o !== 2'b00 || bus.phy_start_o !== 1'b0) ok = 1'b0;
        end
        @(negedge clk);
        bus.phy_datard_i = 1'b0;
        chk({tag, "/gap"},       32'(ok), 32'd1);
        chk({tag, "/gap_idle"},  32'(bus.busy_o), 32'd0);
`ifdef ETH_SCHED_STATS_EN
        for (int r = 0; r < NREQ; r++) begin
            chk({tag, "/pkt_cnt"}, 32'(bus.pkt_cnt_o[r*16 +: 16]), 32'(exp_pkt[r]));
            chk({tag, "/err_cnt"}, 32'(bus.err_cnt_o[r*16 +: 16]), 32'(exp_err[r]));
        end
`endif
    endtask

    initial begin
        vecs[0] = '{req:2'b01, len0:16'd4,    len1:16'd0,    gidx:0, exp_len:16'd4,    exp_start:1'b1, mode:M_NORM, drop:1'b0};
        vecs[1] = '{req:2'b11, len0:16'd8,    len1:16'd8,    gidx:1, exp_len:16'd8,    exp_start:1'b1, mode:M_NORM, drop:1'b0};
        vecs[2] = '{req:2'b11, len0:16'd8,    len1:16'd8,    gidx:0, exp_len:16'd8,    exp_start:1'b1, mode:M_NORM, drop:1'b1};
        vecs[3] = '{req:2'b11, len0:16'd8,    len1:16'd8,    gidx:1, exp_len:16'd8,    exp_start:1'b1, mode:M_NORM, drop:1'b0};
        vecs[4] = '{req:2'b10, len0:16'd8,    len1:16'd0,    gidx:1, exp_len:16'd0,    exp_start:1'b0, mode:M_ZERO, drop:1'b0};
        vecs[5] = '{req:2'b01, len0:16'd2000, len1:16'd0,    gidx:0, exp_len:16'd1472, exp_start:1'b1, mode:M_NORM, drop:1'b0};
        vecs[6] = '{req:2'b01, len0:16'd1,    len1:16'd0,    gidx:0, exp_len:16'd1,    exp_start:1'b1, mode:M_NORM, drop:1'b0};
        vecs[7] = '{req:2'b10, len0:16'd0,    len1:16'd1473, gidx:1, exp_len:16'd1472, exp_start:1'b1, mode:M_NORM, drop:1'b0};
        vecs[8] = '{req:2'b11, len0:16'd5,    len1:16'd3,    gidx:0, exp_len:16'd5,    exp_start:1'b1, mode:M_TMO,  drop:1'b0};
        vecs[9] = '{req:2'b11, len0:16'd5,    len1:16'd3,    gidx:1, exp_len:16'd3,    exp_start:1'b1, mode:M_NORM, drop:1'b0};
        post    = '{req:2'b11, len0:16'd2,    len1:16'd2,    gidx:0, exp_len:16'd2,    exp_start:1'b1, mode:M_NORM, drop:1'b0};

        bus.req_i        = '0;
        bus.len_i        = '0;
        bus.udpport_i    = '0;
        bus.data_i       = '0;
        bus.phy_datard_i = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            exp_pkt[r] = 0;
            exp_err[r] = 0;
        end

        repeat (3) @(negedge clk);
        chk("reset/grant", 32'(bus.grant_o), 32'd0);
        chk("reset/busy",  32'(bus.busy_o), 32'd0);
        chk("reset/len",   32'(bus.phy_len_o), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset asserted in the middle of a stream.
        bus.req_i     = 2'b01;
        bus.len_i     = {16'd0, 16'd10};
        bus.udpport_i = {16'hC001, 16'hC000};
        @(negedge clk);
        chk("mid/grant", 32'(bus.grant_o), 32'd1);
        for (int b = 0; b < 3; b++) begin
            bus.data_i       = {dval(1, b + 1), dval(0, b + 1)};
            bus.phy_datard_i = 1'b1;
            @(negedge clk);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("mid/grant0",  32'(bus.grant_o), 32'd0);
        chk("mid/datard0", 32'(bus.datard_o), 32'd0);
        chk("mid/data0",   32'(bus.phy_data_o), 32'd0);
        chk("mid/busy0",   32'(bus.busy_o), 32'd0);
        chk("mid/start0",  32'(bus.phy_start_o), 32'd0);
        chk("mid/len0",    32'(bus.phy_len_o), 32'd0);
        chk("mid/port0",   32'(bus.phy_udpport_o), 32'd0);
        chk("mid/done0",   32'(bus.done_o), 32'd0);
        chk("mid/err0",    32'(bus.err_o), 32'd0);
        bus.phy_datard_i = 1'b0;
        bus.req_i        = '0;
        for (int r = 0; r < NREQ; r++) begin
            exp_pkt[r] = 0;
            exp_err[r] = 0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid/idle", 32'(bus.busy_o), 32'd0);
        run_vec(post, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
